amo_mem_responder: RTL and testbench
====================================

Name: amo_mem_responder

Overview:
Memory-side responder for RV32A atomic requests from the core's data path. Accepts one LR/SC/AMO request, runs the read-modify-write or reservation-checked store against a single-port data-memory interface, and returns the RISC-V result value. Holds the hart's LR reservation and clears it on snooped writes from other masters. Sits between the core's atomic issue logic and the data bus.

Parameters:
XLEN, 32, data/address width
RESV_TIMEOUT, 64, cycles after LR before the reservation expires (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core request valid
req_ready  out  1  responder can accept a request
req_op  in  5  funct5: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  rs2 value
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  XLEN  rd result
resp_err  out  1  misaligned or unsupported request
mem_req  out  1  memory access request
mem_we  out  1  1 = write
mem_addr  out  XLEN  memory address
mem_wdata  out  XLEN  memory write data
mem_ack  in  1  memory access complete; mem_rdata valid on reads
mem_rdata  in  XLEN  memory read data
snoop_valid  in  1  another master wrote memory
snoop_addr  in  XLEN  address of that write

Behaviour:
- FSM states: IDLE, RD, WR, RESP. Reset to IDLE. Outputs at reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Reservation invalid.
- IDLE: req_ready=1. On req_valid, latch op, addr, and wdata; req_ready=0 in every other state.
  - addr[1:0]!=0 or unknown op -> RESP with resp_err=1, resp_rdata=0, no memory access.
  - LR or AMO -> RD.
  - SC with reservation valid and resv_addr[XLEN-1:2]==addr[XLEN-1:2] -> WR with mem_wdata=wdata. Otherwise -> RESP, resp_rdata=1, no memory access.
  - Every SC clears the reservation, whether it succeeds or fails.
- RD: mem_req=1, mem_we=0, mem_addr=addr. On mem_ack, capture old=mem_rdata.
  - LR -> set the reservation to addr, then RESP.
  - AMO -> compute new, then WR.
- AMO arithmetic uses old (memory value) and wdata (rs2), full XLEN width with wrap-around on ADD.
  - SWAP=wdata; ADD=old+wdata; XOR/AND/OR are bitwise.
  - MIN/MAX are signed compares; MINU/MAXU are unsigned.
  - On equal operands, either value is correct because they are identical.
- WR: mem_req=1, mem_we=1, mem_wdata=new (or the SC data). On mem_ack -> RESP. An AMO write whose word matches the reservation clears it.
- mem_addr, mem_we, and mem_wdata stay stable while mem_req=1 until mem_ack.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata=old for AMO/LR, 0 for a successful SC, 1 for a failed SC.
  - resp_err is valid only with resp_valid.
- Latency with zero-wait memory (mem_ack in the same cycle as mem_req), counted from the accept edge:
  - AMO: RESP at cycle 3.
  - LR and successful SC: RESP at cycle 2.
  - Failed SC or error: RESP at cycle 1.
- Snoop: snoop_valid with a word-address match clears the reservation in any state.
  - A snoop in the same cycle as an SC accept takes priority, so that SC fails.
  - A snoop in the same cycle as the LR reservation set takes priority over the set when addresses match.
- Reset mid-operation returns to IDLE immediately, drops mem_req, clears the reservation, and emits no response.

Optional Feature:
AMO_RESV_TIMEOUT_EN:
- Defined: a counter loads RESV_TIMEOUT when the reservation is set. It decrements each cycle while the reservation is valid. The reservation clears when the count reaches 0, so an SC issued RESV_TIMEOUT or more cycles after the LR response fails.
- Undefined: no counter. The reservation persists until cleared by SC, snoop, matching AMO write, or reset.

Test Plan:
- mem[0x100]=5; AMOADD addr 0x100, wdata 0xFFFFFFFF, zero-wait memory -> resp_rdata=5, mem write 4, resp_valid at cycle 3.
- mem[0x40]=0x80000000; AMOMIN wdata 1 -> writes 0x80000000. Same setup with AMOMINU wdata 1 -> writes 1. Both return 0x80000000.
- LR 0x200, then SC 0x200 data 0xAB -> resp_rdata 0 and memory written 0xAB. A second SC to 0x200 -> resp_rdata 1, no mem_req.
- LR 0x200, then snoop_valid with snoop_addr 0x202, then SC 0x200 -> SC fails with 1 and no write. Repeat with snoop_addr 0x204 -> SC succeeds.
- AMOSWAP at addr 0x103 -> resp_err=1 within 1 cycle, mem_req never asserted. Op 11111 behaves the same.
- mem_ack delayed 3 cycles on the read -> mem_addr and mem_we held stable throughout. Assert rst_n low during WR -> mem_req=0 immediately and no resp_valid. With AMO_RESV_TIMEOUT_EN, an SC issued 64 cycles after the LR response fails.

Source files
------------

// File: rtl/amo_mem_responder_if.sv
// Bundle of the atomic request/response, data-memory and snoop signals
// seen by amo_mem_responder. The slave modport is the responder's view;
// the master modport is the surrounding core/bus view.
interface amo_mem_responder_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_op;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            snoop_valid;
    logic [XLEN-1:0] snoop_addr;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata, snoop_valid, snoop_addr
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata, snoop_valid, snoop_addr
    );
endinterface

// File: rtl/amo_mem_responder.sv
// RV32A memory-side responder: runs LR/SC/AMO against a single-port data
// memory and holds the hart's LR reservation (cleared by SC, snooped
// writes from other masters and matching AMO writes).
// Optional macro AMO_RESV_TIMEOUT_EN: reservation expires RESV_TIMEOUT
// cycles after it is set.
module amo_mem_responder #(
    parameter int XLEN         = 32,
    parameter int RESV_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    amo_mem_responder_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_RESP = 2'd3;

    localparam logic [4:0] OP_ADD  = 5'b00000, OP_SWAP = 5'b00001, OP_LR   = 5'b00010,
                           OP_SC   = 5'b00011, OP_XOR  = 5'b00100, OP_OR   = 5'b01000,
                           OP_AND  = 5'b01100, OP_MIN  = 5'b10000, OP_MAX  = 5'b10100,
                           OP_MINU = 5'b11000, OP_MAXU = 5'b11100;

    logic [1:0]      state;
    logic [4:0]      op_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;   // rs2 at accept, then the value to store
    logic [XLEN-1:0] result_q;
    logic            err_q;
    logic            resv_valid;
    logic [XLEN-3:0] resv_word;

    logic            op_known, sc_ok, snoop_resv, lr_set, amo_hit, sc_accept, resv_expire;
    logic            mem_req, mem_we, resp_valid;

    function automatic logic [XLEN-1:0] amo_alu(input logic [4:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_MIN:  return ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  return ($signed(a) > $signed(b)) ? a : b;
            OP_MINU: return (a < b) ? a : b;
            OP_MAXU: return (a > b) ? a : b;
            default: return b;  // SWAP
        endcase
    endfunction

    // Decode which funct5 encodings this responder supports.
    always_comb begin
        op_known = 1'b0;
        case (bus.req_op)
            OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    // A snoop on the reserved word beats an SC accepted in the same cycle.
    assign snoop_resv = bus.snoop_valid && (bus.snoop_addr[XLEN-1:2] == resv_word);
    assign sc_ok      = resv_valid && (resv_word == bus.req_addr[XLEN-1:2]) && !snoop_resv;
    assign sc_accept  = (state == S_IDLE) && bus.req_valid && (bus.req_op == OP_SC);
    // A snoop to the LR address in the set cycle wins over the set.
    assign lr_set     = (state == S_RD) && bus.mem_ack && (op_q == OP_LR) &&
                        !(bus.snoop_valid && (bus.snoop_addr[XLEN-1:2] == addr_q[XLEN-1:2]));
    assign amo_hit    = (state == S_WR) && bus.mem_ack && (op_q != OP_SC) &&
                        (addr_q[XLEN-1:2] == resv_word);

`ifdef AMO_RESV_TIMEOUT_EN
    localparam int CW = $clog2(RESV_TIMEOUT + 1);
    logic [CW-1:0] resv_cnt;

    // Count down the reservation lifetime; expiry fires on its last live cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            resv_cnt <= '0;
        else if (lr_set)
            resv_cnt <= CW'(RESV_TIMEOUT);
        else if (resv_valid && resv_cnt != '0)
            resv_cnt <= resv_cnt - CW'(1);
    end

    assign resv_expire = resv_valid && (resv_cnt == CW'(1));
`else
    logic unused_timeout;
    assign resv_expire    = 1'b0;
    assign unused_timeout = ^RESV_TIMEOUT;
`endif

    // Reservation: LR set has priority, then any clearing source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid <= 1'b0;
            resv_word  <= '0;
        end else if (lr_set) begin
            resv_valid <= 1'b1;
            resv_word  <= addr_q[XLEN-1:2];
        end else if (snoop_resv || sc_accept || amo_hit || resv_expire) begin
            resv_valid <= 1'b0;
        end
    end

    // Main sequencer: accept, read, modify/store, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    op_q     <= bus.req_op;
                    addr_q   <= bus.req_addr;
                    wdata_q  <= bus.req_wdata;
                    err_q    <= 1'b0;
                    result_q <= '0;
                    if (bus.req_addr[1:0] != 2'b00 || !op_known) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else if (bus.req_op == OP_SC) begin
                        if (sc_ok) begin
                            state <= S_WR;
                        end else begin
                            result_q <= XLEN'(1);
                            state    <= S_RESP;
                        end
                    end else begin
                        state <= S_RD;
                    end
                end
                S_RD: if (bus.mem_ack) begin
                    result_q <= bus.mem_rdata;
                    if (op_q == OP_LR) begin
                        state <= S_RESP;
                    end else begin
                        wdata_q <= amo_alu(op_q, bus.mem_rdata, wdata_q);
                        state   <= S_WR;
                    end
                end
                S_WR:   if (bus.mem_ack) state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = (state == S_RD) || (state == S_WR);
    assign mem_we     = (state == S_WR);
    assign resp_valid = (state == S_RESP);

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_req ? addr_q : '0;
    assign bus.mem_wdata  = mem_we ? wdata_q : '0;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_valid ? result_q : '0;
    assign bus.resp_err   = resp_valid && err_q;

    logic unused_bits;
    assign unused_bits = ^bus.snoop_addr[1:0];
endmodule

// File: tb/tb_amo_mem_responder.sv
// Randomized self-checking bench for amo_mem_responder: a memory model with
// configurable wait states, a transaction-level reference model, and one
// per-cycle compare process.
module tb_amo_mem_responder;
    localparam int XLEN = 32;
    localparam int RESV_TIMEOUT = 64;

    localparam logic [4:0] ADD = 5'b00000, SWAP = 5'b00001, LR = 5'b00010, SC = 5'b00011,
                           XOR = 5'b00100, OR = 5'b01000, AND = 5'b01100, MIN = 5'b10000,
                           MAX = 5'b10100, MINU = 5'b11000, MAXU = 5'b11100, BAD = 5'b11111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    amo_mem_responder_if #(.XLEN(XLEN)) bus ();
    amo_mem_responder #(.XLEN(XLEN), .RESV_TIMEOUT(RESV_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [4:0]  op;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    int checks = 0, errors = 0, cyc = 0;
    int wait_fixed = 0, wait_max = 0;
    int wait_acc = 0, acc_cnt = 0, wr_cnt = 0, resp_seen = 0;
    bit busy = 0;
    logic [31:0] phys_mem [256];
    logic [31:0] ref_mem  [256];
    bit          m_resv_valid = 0;
    logic [29:0] m_resv_word = '0;
    int          m_resv_cyc = 0;
    exp_t        exp_q[$];
    logic [31:0] last_rdata;
    bit          last_err;
    int          last_lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_amo(input logic [4:0] op, input logic [31:0] m,
                                            input logic [31:0] r);
        case (op)
            ADD:     return m + r;
            SWAP:    return r;
            XOR:     return m ^ r;
            OR:      return m | r;
            AND:     return m & r;
            MIN:     return (int'(m) < int'(r)) ? m : r;
            MAX:     return (int'(m) > int'(r)) ? m : r;
            MINU:    return (m < r) ? m : r;
            default: return (m > r) ? m : r;
        endcase
    endfunction

    // Transaction-level model: decides response, latency and memory effects.
    task automatic model_step(input logic [4:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit snp, input logic [31:0] saddr,
                              input int ea, output exp_t e, output int xacc, output int xwr);
        bit known, ok;
        logic [7:0] idx;
        logic [31:0] old;
        idx = addr[9:2];
        known = op inside {ADD, SWAP, LR, SC, XOR, OR, AND, MIN, MAX, MINU, MAXU};
        if (snp && m_resv_valid && saddr[31:2] == m_resv_word) m_resv_valid = 0;
        e.op = op; e.acc = ea; e.err = 0;
        if (addr[1:0] != 2'b00 || !known) begin
            e.err = 1; e.rdata = 0; e.lat = 1; xacc = 0; xwr = 0;
            if (op == SC) m_resv_valid = 0;
        end else if (op == LR) begin
            e.rdata = ref_mem[idx]; e.lat = 2; xacc = 1; xwr = 0;
            m_resv_valid = 1; m_resv_word = addr[31:2];
        end else if (op == SC) begin
            ok = m_resv_valid && m_resv_word == addr[31:2];
`ifdef AMO_RESV_TIMEOUT_EN
            ok = ok && (ea - m_resv_cyc <= RESV_TIMEOUT);
`endif
            m_resv_valid = 0;
            if (ok) begin
                ref_mem[idx] = wdata; e.rdata = 0; e.lat = 2; xacc = 1; xwr = 1;
            end else begin
                e.rdata = 1; e.lat = 1; xacc = 0; xwr = 0;
            end
        end else begin
            old = ref_mem[idx];
            ref_mem[idx] = ref_amo(op, old, wdata);
            e.rdata = old; e.lat = 3; xacc = 2; xwr = 1;
            if (m_resv_word == addr[31:2]) m_resv_valid = 0;
        end
    endtask

    task automatic do_req(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit snp, input logic [31:0] saddr);
        exp_t e;
        int xacc, xwr, acc0, wr0, seen0;
        @(negedge clk);
        model_step(op, addr, wdata, snp, saddr, cyc + 1, e, xacc, xwr);
        bus.req_valid = 1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.snoop_valid = snp; bus.snoop_addr = saddr;
        @(posedge clk); #1;
        busy = 1; wait_acc = 0; acc0 = acc_cnt; wr0 = wr_cnt; seen0 = resp_seen;
        e.acc = cyc;
        exp_q.push_back(e);
        bus.req_valid = 0; bus.snoop_valid = 0;
        for (int n = 0; n < 100 && resp_seen == seen0; n++) @(posedge clk);
        if (resp_seen == seen0) begin
            checks++; errors++;
            $display("FAIL resp_timeout: no response for op %b addr %h", op, addr);
            exp_q.delete(); busy = 0;
        end
        chk("mem_accesses", acc_cnt - acc0, xacc);
        chk("mem_writes", wr_cnt - wr0, xwr);
        chk("mem_word", phys_mem[addr[9:2]], ref_mem[addr[9:2]]);
    endtask

    task automatic snoop_pulse(input logic [31:0] a);
        @(negedge clk);
        bus.snoop_valid = 1; bus.snoop_addr = a;
        if (m_resv_valid && a[31:2] == m_resv_word) m_resv_valid = 0;
        @(posedge clk); #1;
        bus.snoop_valid = 0;
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        phys_mem[a[9:2]] = v; ref_mem[a[9:2]] = v;
    endtask

    initial forever @(posedge clk) cyc++;

    // Data memory: serves reads, commits writes, checks request stability.
    initial begin
        int wl;
        bit in_acc, have_prev;
        logic [31:0] p_addr, p_wdata;
        logic p_we;
        logic [7:0] idx;
        in_acc = 0; have_prev = 0; wl = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        forever @(negedge clk) begin
            if (!rst_n || !bus.mem_req) begin
                bus.mem_ack = 0; in_acc = 0; have_prev = 0;
            end else begin
                if (!in_acc) begin
                    in_acc = 1; have_prev = 0;
                    wl = (wait_fixed >= 0) ? wait_fixed : $urandom_range(0, wait_max);
                end
                if (have_prev) begin
                    chk("mem_addr_stable", bus.mem_addr, p_addr);
                    chk("mem_we_stable", bus.mem_we, p_we);
                    chk("mem_wdata_stable", bus.mem_wdata, p_wdata);
                end
                if (wl == 0) begin
                    bus.mem_ack = 1;
                    idx = bus.mem_addr[9:2];
                    if (bus.mem_we) begin
                        phys_mem[idx] = bus.mem_wdata; wr_cnt++;
                        bus.mem_rdata = $urandom;
                    end else begin
                        bus.mem_rdata = phys_mem[idx];
                    end
                    acc_cnt++; in_acc = 0; have_prev = 0;
                end else begin
                    bus.mem_ack = 0; wl--; wait_acc++;
                    p_addr = bus.mem_addr; p_we = bus.mem_we; p_wdata = bus.mem_wdata;
                    have_prev = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model's expectations.
    initial begin
        exp_t e;
        forever @(negedge clk) begin
            if (rst_n) begin
                chk("req_ready", bus.req_ready, !busy);
                if (bus.resp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: rdata %h err %b", bus.resp_rdata, bus.resp_err);
                    end else begin
                        e = exp_q.pop_front();
                        last_rdata = bus.resp_rdata; last_err = bus.resp_err;
                        last_lat = cyc - e.acc + 1;
                        chk("resp_rdata", bus.resp_rdata, e.rdata);
                        chk("resp_err", bus.resp_err, e.err);
                        chk("resp_latency", last_lat, e.lat + wait_acc);
                        if (e.op == LR && !e.err) m_resv_cyc = cyc;
                        resp_seen++;
                        busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        bit ok;
        logic [4:0] op;
        logic [31:0] a, sa;
        logic [4:0] ops [12];
        ops = '{ADD, SWAP, LR, SC, XOR, OR, AND, MIN, MAX, MINU, MAXU, 5'b00101};
        for (int i = 0; i < 256; i++) begin phys_mem[i] = '0; ref_mem[i] = '0; end
        bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0;
        bus.snoop_valid = 0; bus.snoop_addr = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        rst_n = 1;

        // AMOADD wrap-around, zero-wait latency 3
        set_word(32'h100, 5);
        do_req(ADD, 32'h100, 32'hFFFF_FFFF, 0, 0);
        chk("lit_add_rdata", last_rdata, 5);
        chk("lit_add_mem", phys_mem[32'h100 >> 2], 4);
        chk("lit_add_lat", last_lat, 3);

        // Signed vs unsigned minimum
        set_word(32'h40, 32'h8000_0000);
        do_req(MIN, 32'h40, 1, 0, 0);
        chk("lit_min_rdata", last_rdata, 32'h8000_0000);
        chk("lit_min_mem", phys_mem[32'h40 >> 2], 32'h8000_0000);
        set_word(32'h40, 32'h8000_0000);
        do_req(MINU, 32'h40, 1, 0, 0);
        chk("lit_minu_rdata", last_rdata, 32'h8000_0000);
        chk("lit_minu_mem", phys_mem[32'h40 >> 2], 1);

        // LR/SC pair, then a second SC fails
        set_word(32'h200, 32'h1234);
        do_req(LR, 32'h200, 0, 0, 0);
        chk("lit_lr_rdata", last_rdata, 32'h1234);
        chk("lit_lr_lat", last_lat, 2);
        do_req(SC, 32'h200, 32'hAB, 0, 0);
        chk("lit_sc_ok", last_rdata, 0);
        chk("lit_sc_lat", last_lat, 2);
        chk("lit_sc_mem", phys_mem[32'h200 >> 2], 32'hAB);
        do_req(SC, 32'h200, 32'hCD, 0, 0);
        chk("lit_sc2_fail", last_rdata, 1);
        chk("lit_sc2_lat", last_lat, 1);
        chk("lit_sc2_mem", phys_mem[32'h200 >> 2], 32'hAB);

        // Snoop on same word kills reservation; neighbouring word does not
        do_req(LR, 32'h200, 0, 0, 0);
        snoop_pulse(32'h202);
        do_req(SC, 32'h200, 32'h11, 0, 0);
        chk("lit_snoop_same", last_rdata, 1);
        do_req(LR, 32'h200, 0, 0, 0);
        snoop_pulse(32'h204);
        do_req(SC, 32'h200, 32'h22, 0, 0);
        chk("lit_snoop_other", last_rdata, 0);
        chk("lit_snoop_other_mem", phys_mem[32'h200 >> 2], 32'h22);
        do_req(LR, 32'h200, 0, 0, 0);
        do_req(SC, 32'h200, 32'h33, 1, 32'h201);
        chk("lit_snoop_with_sc", last_rdata, 1);

        // Errors: misaligned and unknown op
        do_req(SWAP, 32'h103, 7, 0, 0);
        chk("lit_misalign_err", last_err, 1);
        chk("lit_misalign_rdata", last_rdata, 0);
        chk("lit_misalign_lat", last_lat, 1);
        do_req(BAD, 32'h100, 7, 0, 0);
        chk("lit_badop_err", last_err, 1);

        // Slow memory: 3 wait states per access
        wait_fixed = 3;
        set_word(32'h100, 10);
        do_req(ADD, 32'h100, 6, 0, 0);
        chk("lit_slow_rdata", last_rdata, 10);
        chk("lit_slow_lat", last_lat, 9);
        chk("lit_slow_mem", phys_mem[32'h100 >> 2], 16);

        // Reset during the write phase
        wait_fixed = 6;
        set_word(32'h80, 7);
        @(negedge clk);
        bus.req_valid = 1; bus.req_op = ADD; bus.req_addr = 32'h80; bus.req_wdata = 1;
        @(posedge clk); #1;
        bus.req_valid = 0; busy = 1;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = bus.mem_we;
        end
        chk("rst_reached_wr", ok, 1);
        #2; rst_n = 0; #1;
        chk("rst_mid_mem_req", bus.mem_req, 0);
        chk("rst_mid_resp_valid", bus.resp_valid, 0);
        busy = 0; m_resv_valid = 0;
        @(posedge clk); #1; rst_n = 1;
        seen0 = resp_seen;
        repeat (8) @(negedge clk);
        chk("rst_mid_no_resp", resp_seen - seen0, 0);
        chk("rst_mid_no_write", phys_mem[32'h80 >> 2], 7);

`ifdef AMO_RESV_TIMEOUT_EN
        wait_fixed = 0;
        do_req(LR, 32'h300, 0, 0, 0);
        repeat (62) @(posedge clk);
        do_req(SC, 32'h300, 32'h55, 0, 0);
        chk("lit_timeout_63", last_rdata, 0);
        do_req(LR, 32'h300, 0, 0, 0);
        repeat (63) @(posedge clk);
        do_req(SC, 32'h300, 32'h66, 0, 0);
        chk("lit_timeout_64", last_rdata, 1);
`endif

        // Randomized traffic against the model
        wait_fixed = -1; wait_max = 3;
        for (int i = 0; i < 4; i++) set_word(32'h100 + i * 4, $urandom);
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 7))
                0, 1: op = LR;
                2, 3: op = SC;
                default: op = ops[$urandom_range(0, 11)];
            endcase
            a = 32'h100 + ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
            sa = 32'h100 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) snoop_pulse(sa);
            do_req(op, a, $urandom, ($urandom_range(0, 3) == 0), sa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
